// File: rtl/keypad_matrix_ctrl.sv
// Matrix keypad scanner with per-key debounce and a show-ahead event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_matrix_ctrl #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COLS-1:0]                 col,
    output logic [ROWS-1:0]                 row,
    output logic [$clog2(ROWS)-1:0]         row_index,
    output logic [ROWS*COLS-1:0]            key_state,
    output logic [$clog2(ROWS*COLS):0]      evt_data,
    output logic                            evt_valid,
    input  logic                            evt_rd,
    output logic [$clog2(FIFO_DEPTH):0]     evt_count,
    output logic                            overflow,
    input  logic                            ovf_clear,
    output logic                            irq
);

    localparam int KEYS  = ROWS * COLS;
    localparam int KW    = $clog2(KEYS);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int DWELL = SCAN_DIV + COLS;
    localparam int DW    = $clog2(DWELL);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = KW + 1;

    typedef enum logic [0:0] {StReset, StScan} scan_state_e;

    scan_state_e    state_q;
    logic [DW-1:0]  dwell_q;

    // Scan sequencer: row and row_index are registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StReset;
            row       <= '1;
            row_index <= '0;
            dwell_q   <= '0;
        end else begin
            unique case (state_q)
                StReset: begin
                    state_q   <= StScan;
                    row       <= ~ROWS'(1);
                    row_index <= '0;
                    dwell_q   <= '0;
                end
                StScan: begin
                    if (dwell_q == DW'(DWELL - 1)) begin
                        dwell_q <= '0;
                        row     <= {row[ROWS-2:0], row[ROWS-1]};
                        if (row_index == RW'(ROWS - 1)) begin
                            row_index <= '0;
                        end else begin
                            row_index <= row_index + 1'b1;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
            endcase
        end
    end

    logic           eval;
    logic [KW-1:0]  key_k;
    logic [CW-1:0]  col_sel;
    logic           sample;
    logic [3:0]     cnt_q [KEYS];
    logic [3:0]     cnt_inc;
    logic           hit;
    logic           push;
    logic [EW-1:0]  evt_new;

    // One key per cycle is evaluated during the tail of each row dwell.
    always_comb begin
        eval    = 1'b0;
        key_k   = '0;
        col_sel = '0;
        sample  = 1'b0;
        if (state_q == StScan && int'(dwell_q) >= SCAN_DIV) begin
            eval    = 1'b1;
            col_sel = CW'(int'(dwell_q) - SCAN_DIV);
            key_k   = KW'(int'(row_index) * COLS + int'(col_sel));
            sample  = ~col[col_sel];
        end
    end

    assign cnt_inc = cnt_q[key_k] + 4'd1;
    assign hit     = eval && (sample != key_state[key_k]) && (cnt_inc == 4'(DEBOUNCE_CNT));
    assign evt_new = {sample, key_k};

`ifdef KEYPAD_RELEASE_EVT_EN
    assign push = hit;
`else
    assign push = hit & sample;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state <= '0;
            for (int i = 0; i < KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (eval) begin
            if (sample == key_state[key_k]) begin
                cnt_q[key_k] <= '0;
            end else if (hit) begin
                cnt_q[key_k]     <= '0;
                key_state[key_k] <= sample;
            end else begin
                cnt_q[key_k] <= cnt_inc;
            end
        end
    end

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic           full;
    logic           pop;
    logic           wr_en;
    logic           drop;

    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == (PW + 1)'(FIFO_DEPTH));
    assign pop       = evt_rd & evt_valid;
    // A same-cycle pop frees the slot, so a full FIFO can still accept the push.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: evt_count <= evt_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            irq <= evt_valid | overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= evt_new;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_ctrl.sv
// Randomised scoreboard bench for keypad_matrix_ctrl: a virtual keypad drives col from row,
// a frame-position model predicts events, a negedge monitor compares every DUT output.
module tb_keypad_matrix_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int DEPTH    = 4;
    localparam int KEYS     = ROWS * COLS;
    localparam int DWELL    = SCAN_DIV + COLS;
    localparam int FRAME    = ROWS * DWELL;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [1:0]  row_index;
    logic [15:0] key_state;
    logic [4:0]  evt_data;
    logic        evt_valid;
    logic        evt_rd = 1'b0;
    logic [2:0]  evt_count;
    logic        overflow;
    logic        ovf_clear = 1'b0;
    logic        irq;

    logic [15:0] pressed = '0;

    int errors = 0;
    int checks = 0;

    keypad_matrix_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .row_index (row_index),
        .key_state (key_state),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_rd    (evt_rd),
        .evt_count (evt_count),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Virtual keypad: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && pressed[r*COLS+c]) col[c] = 1'b0;
            end
        end
    end

    // Reference model state
    logic [4:0]  exp_q[$];
    int          pos = -1;
    int          cnt_m [KEYS];
    logic [15:0] ks_m = '0;
    bit          ovf_m = 1'b0;
    bit          irq_m = 1'b0;
    bit          pre_valid = 1'b0;
    int          mk;
    bit          ms;
    bit          mdrop;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: pos is the cycle number since scanning began; frame position gives the key under test.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            pos   = -1;
            ks_m  = '0;
            ovf_m = 1'b0;
            irq_m = 1'b0;
            for (int i = 0; i < KEYS; i++) cnt_m[i] = 0;
        end else begin
            mdrop = 1'b0;
            irq_m = pre_valid | ovf_m;
            if (pos >= 0 && (pos % DWELL) >= SCAN_DIV) begin
                mk = ((pos % FRAME) / DWELL) * COLS + (pos % DWELL) - SCAN_DIV;
                ms = pressed[mk];
                if (ms == ks_m[mk]) begin
                    cnt_m[mk] = 0;
                end else begin
                    cnt_m[mk]++;
                    if (cnt_m[mk] == DEB) begin
                        cnt_m[mk] = 0;
                        ks_m[mk]  = ms;
                        if (ms || REL) begin
                            if (exp_q.size() < DEPTH) exp_q.push_back({ms, 4'(mk)});
                            else mdrop = 1'b1;
                        end
                    end
                end
            end
            if (mdrop) ovf_m = 1'b1;
            else if (ovf_clear) ovf_m = 1'b0;
            pos++;
        end
    end

    // Monitor: compares every visible output mid-cycle, then retires the head on a read.
    always @(negedge clk) begin
        logic [3:0] exp_row;
        logic [4:0] exp_head;
        exp_row  = 4'hF;
        if (pos >= 0) exp_row[(pos % FRAME) / DWELL] = 1'b0;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : 5'd0;
        check("row", 32'(row), 32'(exp_row));
        check("row_index", 32'(row_index), (pos >= 0) ? 32'((pos % FRAME) / DWELL) : 32'd0);
        check("key_state", 32'(key_state), 32'(ks_m));
        check("evt_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
        check("evt_count", 32'(evt_count), 32'(exp_q.size()));
        check("evt_data", 32'(evt_data), 32'(exp_head));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("irq", 32'(irq), 32'(irq_m));
        pre_valid = (exp_q.size() > 0);
        if (evt_rd && !rst && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        evt_rd = 1'b1;
        tick(DEPTH + 2);
        evt_rd = 1'b0;
    endtask

    initial begin
        int  dur;
        int  epos;
        bit  hit;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Idle scan, no keys.
        tick(2 * FRAME);

        // Hold key 9 long enough to debounce, read it, then release.
        pressed[9] = 1'b1;
        tick(3 * FRAME + 4);
        evt_rd = 1'b1;
        tick(1);
        evt_rd = 1'b0;
        tick(4);
        pressed[9] = 1'b0;
        tick(4 * FRAME);
        drain();

        // Two-frame glitch must not be accepted.
        pressed[9] = 1'b1;
        tick(2 * FRAME);
        pressed[9] = 1'b0;
        tick(2 * FRAME);

        // Five presses without reading overflow the FIFO.
        for (int k = 0; k < 5; k++) begin
            pressed[k] = 1'b1;
            tick(3 * FRAME + 8);
            pressed[k] = 1'b0;
            tick(3 * FRAME + 8);
        end
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        tick(2);
        drain();

        // Fill the FIFO, then land a push on the same cycle as a pop.
        pressed[13:10] = 4'hF;
        tick(3 * FRAME + 2);
        pressed[14] = 1'b1;
        epos = (14 / COLS) * DWELL + SCAN_DIV + (14 % COLS);
        hit  = 1'b0;
        for (int i = 0; i < 6 * FRAME && !hit; i++) begin
            if ((pos % FRAME) == epos && cnt_m[14] == DEB - 1 && exp_q.size() == DEPTH) begin
                hit    = 1'b1;
                evt_rd = 1'b1;
                tick(1);
                evt_rd = 1'b0;
            end else begin
                tick(1);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL push_with_pop_window got=0 exp=1");
        end
        tick(4);
        pressed = '0;
        tick(4 * FRAME);
        drain();
        drain();

        // Random key activity with random reads and occasional overflow clears.
        for (int it = 0; it < 40; it++) begin
            pressed = pressed ^ (16'd1 << $urandom_range(0, KEYS - 1));
            dur = ($urandom_range(1, 4) * FRAME) + $urandom_range(0, FRAME - 1);
            repeat (dur) begin
                evt_rd    = ($urandom_range(0, 2) == 0);
                ovf_clear = ($urandom_range(0, 39) == 0);
                tick(1);
            end
            if (it == 20) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        end
        evt_rd    = 1'b0;
        ovf_clear = 1'b0;
        pressed   = '0;
        tick(4 * FRAME);
        drain();
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
